sram_sp_masked_array: RTL and testbench

//  Parametrised single-port synchronous SRAM array: the successor to the fixed-shape 64-bit RW0 array models.

---
 rtl/sram_sp_masked_array_if.sv | 30 +++
 rtl/sram_sp_masked_array.sv | 121 ++++++++++++
 tb/tb_sram_sp_masked_array.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_sp_masked_array_if.sv
// Request/response bundle for sram_sp_masked_array: valid/ready request,
// read response, clear control and address-error pulse.
`timescale 1ns/1ps
interface sram_sp_masked_array_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 12,
   parameter int MASK_SEGS  = 8
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic [MASK_SEGS-1:0]  req_wmask;
   logic                  resp_valid;
   logic [DATA_WIDTH-1:0] resp_rdata;
   logic                  init_req;
   logic                  init_busy;
   logic                  addr_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_wmask, init_req,
      input  req_ready, resp_valid, resp_rdata, init_busy, addr_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_wmask, init_req,
      output req_ready, resp_valid, resp_rdata, init_busy, addr_err
   );
endinterface

// File: rtl/sram_sp_masked_array.sv
// Single-port synchronous SRAM array with per-segment write mask, 1- or
// 2-cycle read latency and a clear FSM that fills every entry with
// INIT_VALUE after reset and on request. Read data holds when not valid.
`timescale 1ns/1ps
module sram_sp_masked_array #(
   parameter int                    DATA_WIDTH   = 64,
   parameter int                    DEPTH        = 3072,
   parameter int                    ADDR_WIDTH   = 12,
   parameter int                    MASK_SEGS    = 8,
   parameter int                    READ_LATENCY = 1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
   input logic                   clock,
   input logic                   reset_n,
   sram_sp_masked_array_if.slave bus
);
   localparam int                  SEG_W     = DATA_WIDTH / MASK_SEGS;
   localparam logic [0:0]          ST_INIT   = 1'b0;
   localparam logic [0:0]          ST_READY  = 1'b1;
   localparam logic [ADDR_WIDTH:0] DEPTH_X   = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   if ((DATA_WIDTH % MASK_SEGS) != 0 || !(READ_LATENCY == 1 || READ_LATENCY == 2) ||
       (2**ADDR_WIDTH) < DEPTH) begin : g_bad_cfg
      $fatal(1, "sram_sp_masked_array: illegal parameter combination");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [0:0]            state;
   logic [ADDR_WIDTH-1:0] init_cnt;
   logic                  accept;
   logic                  in_range;
   logic                  rd_acc;
   logic                  vld_p0;
   logic [DATA_WIDTH-1:0] rdata_p0;
   logic                  err_p0;

   assign bus.req_ready = (state == ST_READY);
   assign bus.init_busy = (state == ST_INIT);
   assign accept        = bus.req_valid & bus.req_ready;
   assign in_range      = ({1'b0, bus.req_addr} < DEPTH_X);
   assign rd_acc        = accept & ~bus.req_write;
   assign bus.addr_err  = err_p0;

   // Clear/ready FSM: walk init_cnt over every entry, then accept requests
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_INIT;
         init_cnt <= '0;
      end else begin
         case (state)
            ST_INIT: begin
               if (init_cnt == LAST_ADDR) begin
                  state    <= ST_READY;
                  init_cnt <= '0;
               end else begin
                  init_cnt <= init_cnt + 1'b1;
               end
            end
            default: begin
               if (bus.init_req) begin
                  state    <= ST_INIT;
                  init_cnt <= '0;
               end
            end
         endcase
      end
   end

   // Storage write port: clear writes during INIT, masked writes when ready
   always_ff @(posedge clock) begin
      if (state == ST_INIT) begin
         mem[init_cnt] <= INIT_VALUE;
      end else if (accept && bus.req_write && in_range) begin
         for (int s = 0; s < MASK_SEGS; s++) begin
            if (bus.req_wmask[s]) begin
               mem[bus.req_addr][s*SEG_W +: SEG_W] <= bus.req_wdata[s*SEG_W +: SEG_W];
            end
         end
      end
   end

   // Stage p0: sample the array at acceptance; out-of-range reads give zero
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vld_p0   <= 1'b0;
         rdata_p0 <= '0;
         err_p0   <= 1'b0;
      end else begin
         vld_p0 <= rd_acc;
         err_p0 <= accept & ~in_range;
         if (rd_acc) begin
            rdata_p0 <= in_range ? mem[bus.req_addr] : '0;
         end
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      logic                  vld_p1;
      logic [DATA_WIDTH-1:0] rdata_p1;

      // Stage p1: extra output register, data only moves with a valid beat
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            vld_p1   <= 1'b0;
            rdata_p1 <= '0;
         end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
               rdata_p1 <= rdata_p0;
            end
         end
      end

      assign bus.resp_valid = vld_p1;
      assign bus.resp_rdata = rdata_p1;
   end else begin : g_lat1
      assign bus.resp_valid = vld_p0;
      assign bus.resp_rdata = rdata_p0;
   end
endmodule

// File: tb/tb_sram_sp_masked_array.sv
// Directed bench: dut_a (latency 1, clear to 0) and dut_b (latency 2,
// clear to 16'h00C3) share one clock and one set of stimulus signals.
`timescale 1ns/1ps
module tb_sram_sp_masked_array;
   localparam int DW  = 16;
   localparam int AW  = 4;
   localparam int MS  = 2;
   localparam int DEP = 12;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic rst_a;
   logic rst_b;

   sram_sp_masked_array_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MASK_SEGS(MS)) bus_a ();
   sram_sp_masked_array_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MASK_SEGS(MS)) bus_b ();

   sram_sp_masked_array #(
      .DATA_WIDTH(DW), .DEPTH(DEP), .ADDR_WIDTH(AW), .MASK_SEGS(MS),
      .READ_LATENCY(1), .INIT_VALUE(16'h0000)
   ) dut_a (
      .clock   (clock),
      .reset_n (rst_a),
      .bus     (bus_a.slave)
   );

   sram_sp_masked_array #(
      .DATA_WIDTH(DW), .DEPTH(DEP), .ADDR_WIDTH(AW), .MASK_SEGS(MS),
      .READ_LATENCY(2), .INIT_VALUE(16'h00C3)
   ) dut_b (
      .clock   (clock),
      .reset_n (rst_b),
      .bus     (bus_b.slave)
   );

   logic          sel;
   logic          d_valid;
   logic          d_write;
   logic          d_init;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [MS-1:0] d_wmask;

   assign bus_a.req_valid = ~sel & d_valid;
   assign bus_a.init_req  = ~sel & d_init;
   assign bus_a.req_write = d_write;
   assign bus_a.req_addr  = d_addr;
   assign bus_a.req_wdata = d_wdata;
   assign bus_a.req_wmask = d_wmask;
   assign bus_b.req_valid = sel & d_valid;
   assign bus_b.init_req  = sel & d_init;
   assign bus_b.req_write = d_write;
   assign bus_b.req_addr  = d_addr;
   assign bus_b.req_wdata = d_wdata;
   assign bus_b.req_wmask = d_wmask;

   logic          o_ready, o_rvalid, o_busy, o_aerr;
   logic [DW-1:0] o_rdata;
   assign o_ready  = sel ? bus_b.req_ready  : bus_a.req_ready;
   assign o_rvalid = sel ? bus_b.resp_valid : bus_a.resp_valid;
   assign o_rdata  = sel ? bus_b.resp_rdata : bus_a.resp_rdata;
   assign o_busy   = sel ? bus_b.init_busy  : bus_a.init_busy;
   assign o_aerr   = sel ? bus_b.addr_err   : bus_a.addr_err;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input int a, input logic [DW-1:0] d, input logic [MS-1:0] m);
      d_valid = 1'b1;
      d_write = 1'b1;
      d_addr  = AW'(a);
      d_wdata = d;
      d_wmask = m;
      cyc();
      d_valid = 1'b0;
      d_write = 1'b0;
   endtask

   task automatic rd(input string tag, input int a, input logic [DW-1:0] exp, input int lat);
      d_valid = 1'b1;
      d_write = 1'b0;
      d_addr  = AW'(a);
      cyc();
      d_valid = 1'b0;
      if (lat == 2) begin
         chk({tag, "_early"}, o_rvalid, 0);
         cyc();
      end
      chk({tag, "_vld"}, o_rvalid, 1);
      chk(tag, o_rdata, exp);
   endtask

   task automatic wait_ready(input string tag, input int exp);
      int n = 0;
      while (!o_ready && n < 100) begin
         chk({tag, "_busy"}, o_busy, 1);
         cyc();
         n++;
      end
      chk(tag, n, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [DW-1:0] e;
      sel = 1'b0; d_valid = 1'b0; d_write = 1'b0; d_init = 1'b0;
      d_addr = '0; d_wdata = '0; d_wmask = '0;
      rst_a = 1'b0; rst_b = 1'b0;
      repeat (3) cyc();

      chk("rst_ready", o_ready, 0);
      chk("rst_busy", o_busy, 1);
      chk("rst_rvalid", o_rvalid, 0);
      chk("rst_rdata", o_rdata, 0);
      chk("rst_aerr", o_aerr, 0);

      // 1: clear after reset, then a read of a cleared entry
      rst_a = 1'b1; rst_b = 1'b1;
      wait_ready("t1_clear_a", 12);
      rd("t1_rd5", 5, 16'h0000, 1);

      // 2: masked writes
      wr(3, 16'hABCD, 2'b11);
      wr(3, 16'h1234, 2'b01);
      rd("t2_rd3", 3, 16'hAB34, 1);
      wr(3, 16'h0000, 2'b00);
      rd("t2_mask0", 3, 16'hAB34, 1);

      // 3: read-after-write at latency 1
      wr(7, 16'h5A5A, 2'b11);
      rd("t3_raw", 7, 16'h5A5A, 1);
      chk("t3_aerr", o_aerr, 0);

      // back-to-back reads
      d_valid = 1'b1; d_write = 1'b0; d_addr = 4'd3;
      cyc();
      d_addr = 4'd7;
      chk("b2b_v0", o_rvalid, 1);
      chk("b2b_d0", o_rdata, 16'hAB34);
      cyc();
      d_valid = 1'b0;
      chk("b2b_v1", o_rvalid, 1);
      chk("b2b_d1", o_rdata, 16'h5A5A);
      cyc();
      chk("b2b_idle", o_rvalid, 0);
      chk("b2b_hold", o_rdata, 16'h5A5A);

      // 4: out-of-range read and write
      rd("t4_oor_rd", 12, 16'h0000, 1);
      chk("t4_aerr_rd", o_aerr, 1);
      cyc();
      chk("t4_aerr_rd_end", o_aerr, 0);
      wr(13, 16'hFFFF, 2'b11);
      chk("t4_aerr_wr", o_aerr, 1);
      chk("t4_wr_novld", o_rvalid, 0);
      cyc();
      chk("t4_aerr_wr_end", o_aerr, 0);
      for (int i = 0; i < DEP; i++) begin
         e = (i == 3) ? 16'hAB34 : (i == 7) ? 16'h5A5A : 16'h0000;
         rd($sformatf("t4_scan%0d", i), i, e, 1);
      end

      // 3 (latency 2) on dut_b
      sel = 1'b1;
      wr(7, 16'h5A5A, 2'b11);
      d_valid = 1'b1; d_write = 1'b0; d_addr = 4'd7;
      cyc();
      d_valid = 1'b0;
      chk("t3l2_c1_vld", o_rvalid, 0);
      chk("t3l2_c1_hold", o_rdata, 16'h0000);
      cyc();
      chk("t3l2_c2_vld", o_rvalid, 1);
      chk("t3l2_c2_data", o_rdata, 16'h5A5A);
      cyc();
      chk("t3l2_c3_vld", o_rvalid, 0);
      chk("t3l2_c3_hold", o_rdata, 16'h5A5A);

      // 5: read plus clear request in the same cycle
      for (int i = 0; i < DEP; i++) wr(i, 16'hFFFF, 2'b11);
      d_valid = 1'b1; d_write = 1'b0; d_addr = 4'd2; d_init = 1'b1;
      cyc();
      d_valid = 1'b0; d_init = 1'b0;
      chk("t5_busy0", o_busy, 1);
      chk("t5_vld0", o_rvalid, 0);
      n = 0;
      while (o_busy && n < 100) begin
         if (n == 1) begin
            chk("t5_rd_vld", o_rvalid, 1);
            chk("t5_rd_data", o_rdata, 16'hFFFF);
         end
         cyc();
         n++;
      end
      chk("t5_busy_len", n, 12);
      for (int i = 0; i < DEP; i++) rd($sformatf("t5_scan%0d", i), i, 16'h00C3, 2);

      // 6: reset in the middle of a clear restarts it from entry 0
      wr(1, 16'h1111, 2'b11);
      wr(9, 16'h1111, 2'b11);
      d_init = 1'b1;
      cyc();
      d_init = 1'b0;
      repeat (6) cyc();
      rst_b = 1'b0;
      #1;
      chk("t6_rst_ready", o_ready, 0);
      chk("t6_rst_busy", o_busy, 1);
      chk("t6_rst_rdata", o_rdata, 0);
      cyc();
      rst_b = 1'b1;
      wait_ready("t6_clear", 12);
      for (int i = 0; i < DEP; i++) rd($sformatf("t6_scan%0d", i), i, 16'h00C3, 2);

      // reset with a read in flight: no response afterwards
      d_valid = 1'b1; d_write = 1'b0; d_addr = 4'd4;
      cyc();
      d_valid = 1'b0;
      rst_b = 1'b0;
      #1;
      chk("t6_fl_rst_vld", o_rvalid, 0);
      cyc();
      rst_b = 1'b1;
      n = 0;
      while (!o_ready && n < 100) begin
         chk($sformatf("t6_fl_vld%0d", n), o_rvalid, 0);
         cyc();
         n++;
      end
      chk("t6_fl_clear", n, 12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
